wash_sequencer: RTL and testbench

Program controller for the washing-machine design. It steps a fixed wash program through FILL, WASH, DRAIN, RINSE, DRAIN and SPIN, then sounds a buzzer. Each phase is timed by an internal two-digit BCD down-counter that runs on an external one-cycle time-base strobe. The block drives the actuator enables and the remaining-time BCD digits for the display.

---
 rtl/wash_sequencer_if.sv | 33 +++
 rtl/wash_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_wash_sequencer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wash_sequencer_if.sv
// wash_sequencer_if: groups the time-base/control inputs and the status,
// actuator and display outputs of the wash program controller.
// Signal semantics: TICK is a one-CP-wide strobe, every high cycle counts
// as one time step. START, DOOR and PAUSE are levels sampled on each rising CP.
// All outputs are registered and change only just after a rising CP.
interface wash_sequencer_if;
  logic       TICK;
  logic       START;
  logic       DOOR;
  logic       PAUSE;
  logic [2:0] STATE;
  logic       VALVE;
  logic       MOTOR;
  logic       PUMP;
  logic       SPIN;
  logic       BUZZ;
  logic       BUSY;
  logic       PAUSED;
  logic [3:0] TENS;
  logic [3:0] UNITS;

  // Driver side: the environment that issues commands and watches status.
  modport master (
    output TICK, START, DOOR, PAUSE,
    input  STATE, VALVE, MOTOR, PUMP, SPIN, BUZZ, BUSY, PAUSED, TENS, UNITS
  );

  // Controller side.
  modport slave (
    input  TICK, START, DOOR, PAUSE,
    output STATE, VALVE, MOTOR, PUMP, SPIN, BUZZ, BUSY, PAUSED, TENS, UNITS
  );
endinterface

// File: rtl/wash_sequencer.sv
// wash_sequencer: steps FILL, WASH, DRAIN1, RINSE, DRAIN2, SPINS, DONE with a
// two-digit BCD down-counter clocked by TICK, and drives the actuator enables
// and the remaining-time display digits.
// Optional feature macro: WASH_PAUSE_EN. When it is defined, PAUSE freezes the
// program just like an open door. When it is undefined, PAUSE is ignored.
// The current FSM state is exposed on bus.STATE.
module wash_sequencer #(
  parameter logic [7:0] T_FILL  = 8'h05,
  parameter logic [7:0] T_WASH  = 8'h20,
  parameter logic [7:0] T_DRAIN = 8'h05,
  parameter logic [7:0] T_RINSE = 8'h10,
  parameter logic [7:0] T_SPIN  = 8'h15,
  parameter logic [7:0] T_BUZZ  = 8'h03
) (
  input  logic               CP,
  input  logic               CR,
  wash_sequencer_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_WASH   = 3'd2,
    S_DRAIN1 = 3'd3,
    S_RINSE  = 3'd4,
    S_DRAIN2 = 3'd5,
    S_SPINS  = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  // A zero duration or any non-BCD digit would never reach 01 cleanly, so
  // such values are replaced by the shortest legal phase, 01.
  function automatic logic [7:0] clamp_dur(input logic [7:0] d);
    if (d[7:4] > 4'd9 || d[3:0] > 4'd9 || d == 8'h00) return 8'h01;
    return d;
  endfunction

  localparam logic [7:0] D_FILL  = clamp_dur(T_FILL);
  localparam logic [7:0] D_WASH  = clamp_dur(T_WASH);
  localparam logic [7:0] D_DRAIN = clamp_dur(T_DRAIN);
  localparam logic [7:0] D_RINSE = clamp_dur(T_RINSE);
  localparam logic [7:0] D_SPIN  = clamp_dur(T_SPIN);
  localparam logic [7:0] D_BUZZ  = clamp_dur(T_BUZZ);

  // Duration loaded on entry to each phase.
  function automatic logic [7:0] dur_of(input state_t s);
    logic [7:0] d;
    case (s)
      S_FILL:             d = D_FILL;
      S_WASH:             d = D_WASH;
      S_DRAIN1, S_DRAIN2: d = D_DRAIN;
      S_RINSE:            d = D_RINSE;
      S_SPINS:            d = D_SPIN;
      S_DONE:             d = D_BUZZ;
      default:            d = 8'h00;
    endcase
    return d;
  endfunction

  // Two-digit BCD decrement; x0 borrows into the tens digit.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  state_t     state_q, state_d;
  state_t     next_phase;
  logic [7:0] cnt_q, cnt_d;
  logic       paused_q, paused_d;
  logic       busy_q, busy_d;
  logic       valve_q, valve_d;
  logic       motor_q, motor_d;
  logic       pump_q, pump_d;
  logic       spin_q, spin_d;
  logic       buzz_q, buzz_d;
  logic       hold_req;
  logic       phase_end;

  // Freeze request: the door interlock always, PAUSE only when enabled.
`ifdef WASH_PAUSE_EN
  assign hold_req = bus.DOOR | bus.PAUSE;
`else
  // PAUSE is part of the bus but has no function in this build.
  logic unused_pause;
  assign unused_pause = bus.PAUSE;
  assign hold_req     = bus.DOOR;
`endif

  // A counter of 00 while busy is treated as 01 so the program cannot stall.
  assign phase_end  = (cnt_q == 8'h01) || (cnt_q == 8'h00);
  assign next_phase = state_t'(state_q + 3'd1);

  // Next-state, timer, freeze and actuator decode; outputs come from flops.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    paused_d = 1'b0;
    busy_d   = 1'b0;
    valve_d  = 1'b0;
    motor_d  = 1'b0;
    pump_d   = 1'b0;
    spin_d   = 1'b0;
    buzz_d   = 1'b0;

    if (state_q == S_IDLE) begin
      // A TICK in the accepting cycle is not counted.
      if (bus.START && !bus.DOOR) begin
        state_d = S_FILL;
        cnt_d   = D_FILL;
      end
    end else if (bus.TICK && !paused_q) begin
      // Freezing uses the registered PAUSED, so a TICK in the cycle the door
      // opens still counts, and one in the cycle it closes does not.
      if (phase_end) begin
        if (state_q == S_DONE) begin
          state_d = S_IDLE;
          cnt_d   = 8'h00;
        end else begin
          state_d = next_phase;
          cnt_d   = dur_of(next_phase);
        end
      end else begin
        cnt_d = bcd_dec(cnt_q);
      end
    end

    busy_d   = (state_d != S_IDLE);
    paused_d = busy_d && hold_req;

    if (!paused_d) begin
      case (state_d)
        S_FILL:   valve_d = 1'b1;
        S_WASH:   motor_d = 1'b1;
        S_DRAIN1: pump_d  = 1'b1;
        S_RINSE: begin
          valve_d = 1'b1;
          motor_d = 1'b1;
        end
        S_DRAIN2: pump_d  = 1'b1;
        S_SPINS: begin
          pump_d = 1'b1;
          spin_d = 1'b1;
        end
        S_DONE:   buzz_d  = 1'b1;
        default:  ;
      endcase
    end
  end

  // State register with synchronous reset that overrides every other input.
  always_ff @(posedge CP) begin
    if (CR) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'h00;
      paused_q <= 1'b0;
      busy_q   <= 1'b0;
      valve_q  <= 1'b0;
      motor_q  <= 1'b0;
      pump_q   <= 1'b0;
      spin_q   <= 1'b0;
      buzz_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      paused_q <= paused_d;
      busy_q   <= busy_d;
      valve_q  <= valve_d;
      motor_q  <= motor_d;
      pump_q   <= pump_d;
      spin_q   <= spin_d;
      buzz_q   <= buzz_d;
    end
  end

  assign bus.STATE  = state_q;
  assign bus.TENS   = cnt_q[7:4];
  assign bus.UNITS  = cnt_q[3:0];
  assign bus.BUSY   = busy_q;
  assign bus.PAUSED = paused_q;
  assign bus.VALVE  = valve_q;
  assign bus.MOTOR  = motor_q;
  assign bus.PUMP   = pump_q;
  assign bus.SPIN   = spin_q;
  assign bus.BUZZ   = buzz_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// tb_wash_sequencer: drives two controllers with the same inputs, one with the
// default durations and one with zero / non-BCD durations that must clamp to
// 01. A behavioural model counting remaining ticks as plain integers predicts
// every output vector each cycle.
module tb_wash_sequencer;

  // ---------------- clock / reset ----------------
  logic cp = 1'b0;
  logic cr;
  always #5 cp = ~cp;

  wash_sequencer_if bus_a ();
  wash_sequencer_if bus_b ();

  assign bus_b.TICK  = bus_a.TICK;
  assign bus_b.START = bus_a.START;
  assign bus_b.DOOR  = bus_a.DOOR;
  assign bus_b.PAUSE = bus_a.PAUSE;

  wash_sequencer dut_a (
    .CP  (cp),
    .CR  (cr),
    .bus (bus_a.slave)
  );

  wash_sequencer #(
    .T_FILL  (8'h00),
    .T_WASH  (8'h3C),
    .T_DRAIN (8'h01),
    .T_RINSE (8'h02),
    .T_SPIN  (8'hA1),
    .T_BUZZ  (8'h00)
  ) dut_b (
    .CP  (cp),
    .CR  (cr),
    .bus (bus_b.slave)
  );

`ifdef WASH_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  // Observed vector: {STATE, VALVE, MOTOR, PUMP, SPIN, BUZZ, BUSY, PAUSED, TENS, UNITS}
  logic [17:0] obs_a, obs_b;
  assign obs_a = {bus_a.STATE, bus_a.VALVE, bus_a.MOTOR, bus_a.PUMP, bus_a.SPIN,
                  bus_a.BUZZ, bus_a.BUSY, bus_a.PAUSED, bus_a.TENS, bus_a.UNITS};
  assign obs_b = {bus_b.STATE, bus_b.VALVE, bus_b.MOTOR, bus_b.PUMP, bus_b.SPIN,
                  bus_b.BUZZ, bus_b.BUSY, bus_b.PAUSED, bus_b.TENS, bus_b.UNITS};

  // ---------------- scoreboard ----------------
  logic [35:0] exp_q[$];
  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_eq(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase lengths in ticks, indexed by state code; row 1 holds the clamped set.
  int dur_tab[2][8] = '{'{0, 5, 20, 5, 10, 5, 15, 3},
                        '{0, 1, 1, 1, 2, 1, 1, 1}};
  int m_state[2];
  int m_rem[2];
  bit m_paused[2];

  bit cr_lvl    = 1'b0;
  bit door_lvl  = 1'b0;
  bit pause_lvl = 1'b0;

  task automatic model_step(input int k, input bit c, input bit start, input bit tick,
                            input bit door, input bit pause);
    if (c) begin
      m_state[k]  = 0;
      m_rem[k]    = 0;
      m_paused[k] = 1'b0;
    end else begin
      if (m_state[k] == 0) begin
        if (start && !door) begin
          m_state[k] = 1;
          m_rem[k]   = dur_tab[k][1];
        end
      end else if (tick && !m_paused[k]) begin
        if (m_rem[k] <= 1) begin
          if (m_state[k] == 7) begin
            m_state[k] = 0;
            m_rem[k]   = 0;
          end else begin
            m_state[k] = m_state[k] + 1;
            m_rem[k]   = dur_tab[k][m_state[k]];
          end
        end else begin
          m_rem[k] = m_rem[k] - 1;
        end
      end
      m_paused[k] = (m_state[k] != 0) && (door || (PAUSE_EN && pause));
    end
  endtask

  function automatic logic [17:0] model_vec(input int k);
    int  s;
    bit  on;
    logic [3:0] tens, units;
    s     = m_state[k];
    on    = !m_paused[k];
    tens  = 4'(m_rem[k] / 10);
    units = 4'(m_rem[k] % 10);
    return {3'(s),
            on && (s == 1 || s == 4),
            on && (s == 2 || s == 4),
            on && (s == 3 || s == 5 || s == 6),
            on && (s == 6),
            on && (s == 7),
            s != 0,
            m_paused[k],
            tens, units};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_cycle(input bit start, input bit tick);
    logic [35:0] exp;
    cr          = cr_lvl;
    bus_a.START = start;
    bus_a.TICK  = tick;
    bus_a.DOOR  = door_lvl;
    bus_a.PAUSE = pause_lvl;
    for (int k = 0; k < 2; k++) model_step(k, cr_lvl, start, tick, door_lvl, pause_lvl);
    exp_q.push_back({model_vec(1), model_vec(0)});
    @(posedge cp);
    #1;
    exp = exp_q.pop_front();
    check_eq("vec_a", {18'd0, obs_a}, {18'd0, exp[17:0]});
    check_eq("vec_b", {18'd0, obs_b}, {18'd0, exp[35:18]});
    bus_a.START = 1'b0;
    bus_a.TICK  = 1'b0;
  endtask

  // TICKs separated by random idle gaps.
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      drive_cycle(1'b0, 1'b1);
      repeat ($urandom_range(0, 2)) drive_cycle(1'b0, 1'b0);
    end
  endtask

  function automatic logic [7:0] cnt_a();
    return {bus_a.TENS, bus_a.UNITS};
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    bus_a.START = 1'b0;
    bus_a.TICK  = 1'b0;
    bus_a.DOOR  = 1'b0;
    bus_a.PAUSE = 1'b0;
    cr          = 1'b1;
    for (int k = 0; k < 2; k++) begin
      m_state[k]  = 0;
      m_rem[k]    = 0;
      m_paused[k] = 1'b0;
    end

    // Reset held for two cycles from an unknown state.
    cr_lvl = 1'b1;
    drive_cycle(1'b1, 1'b1);
    drive_cycle(1'b0, 1'b0);
    check_eq("reset_zero", {18'd0, obs_a}, 36'd0);
    cr_lvl = 1'b0;

    // Full program; the TICK coincident with START must be ignored.
    drive_cycle(1'b1, 1'b1);
    check_eq("fill_state", bus_a.STATE, 3'd1);
    check_eq("fill_valve", bus_a.VALVE, 1'b1);
    check_eq("fill_cnt", cnt_a(), 8'h05);
    tick_n(5);
    check_eq("wash_state", bus_a.STATE, 3'd2);
    check_eq("wash_cnt", cnt_a(), 8'h20);
    check_eq("wash_motor", bus_a.MOTOR, 1'b1);
    tick_n(1);
    check_eq("bcd_borrow", cnt_a(), 8'h19);
    tick_n(56);
    check_eq("done_state", bus_a.STATE, 3'd7);
    check_eq("done_buzz", bus_a.BUZZ, 1'b1);
    tick_n(1);
    check_eq("tick63_idle", bus_a.STATE, 3'd0);
    check_eq("tick63_busy", bus_a.BUSY, 1'b0);

    // START with the door open in IDLE is ignored.
    door_lvl = 1'b1;
    drive_cycle(1'b1, 1'b0);
    check_eq("door_start", bus_a.STATE, 3'd0);
    check_eq("door_idle_paused", bus_a.PAUSED, 1'b0);
    door_lvl = 1'b0;

    // Door interlock in WASH at 1:2.
    drive_cycle(1'b1, 1'b0);
    tick_n(13);
    check_eq("wash_12", cnt_a(), 8'h12);
    door_lvl = 1'b1;
    drive_cycle(1'b0, 1'b0);
    check_eq("door_motor", bus_a.MOTOR, 1'b0);
    check_eq("door_paused", bus_a.PAUSED, 1'b1);
    tick_n(10);
    check_eq("door_hold_cnt", cnt_a(), 8'h12);
    check_eq("door_hold_state", bus_a.STATE, 3'd2);
    door_lvl = 1'b0;
    drive_cycle(1'b0, 1'b0);
    check_eq("resume_motor", bus_a.MOTOR, 1'b1);
    tick_n(12);
    check_eq("drain1_state", bus_a.STATE, 3'd3);

    // START during RINSE leaves state and counter alone.
    tick_n(5);
    drive_cycle(1'b1, 1'b0);
    check_eq("rinse_start_state", bus_a.STATE, 3'd4);
    check_eq("rinse_start_cnt", cnt_a(), 8'h10);

    // PAUSE in SPINS at 0:7.
    tick_n(23);
    check_eq("spins_07", cnt_a(), 8'h07);
    pause_lvl = 1'b1;
    drive_cycle(1'b0, 1'b0);
    tick_n(5);
`ifdef WASH_PAUSE_EN
    check_eq("pause_pump", bus_a.PUMP, 1'b0);
    check_eq("pause_spin", bus_a.SPIN, 1'b0);
    check_eq("pause_cnt", cnt_a(), 8'h07);
`else
    check_eq("nopause_spin", bus_a.SPIN, 1'b1);
    check_eq("nopause_cnt", cnt_a(), 8'h02);
`endif
    pause_lvl = 1'b0;
    drive_cycle(1'b0, 1'b0);
    tick_n(7);
`ifdef WASH_PAUSE_EN
    check_eq("pause_done", bus_a.STATE, 3'd7);
    check_eq("pause_buzz", bus_a.BUZZ, 1'b1);
`else
    check_eq("nopause_idle", bus_a.STATE, 3'd0);
`endif
    for (int g = 0; g < 20 && m_state[0] != 0; g++) tick_n(1);

    // Reset mid-program in SPINS at 0:4, then restart.
    drive_cycle(1'b1, 1'b0);
    tick_n(56);
    check_eq("spins_04_state", bus_a.STATE, 3'd6);
    check_eq("spins_04_cnt", cnt_a(), 8'h04);
    cr_lvl = 1'b1;
    drive_cycle(1'b1, 1'b1);
    check_eq("midreset_zero", {18'd0, obs_a}, 36'd0);
    cr_lvl = 1'b0;
    drive_cycle(1'b1, 1'b0);
    check_eq("restart_state", bus_a.STATE, 3'd1);
    check_eq("restart_cnt", cnt_a(), 8'h05);

    // Random mix of inputs, checked cycle by cycle against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) door_lvl = ~door_lvl;
      if ($urandom_range(0, 15) == 0) pause_lvl = ~pause_lvl;
      cr_lvl = ($urandom_range(0, 99) == 0);
      drive_cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end
    cr_lvl = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
